// File: rtl/fp_addsub_seq.sv
// Multi-cycle single-precision add/subtract: one operation in flight, fixed
// five-cycle handshake-to-response latency, valid/ready on both sides.
// state | meaning
// IDLE  | ready for a request; operands latched on accept
// ALIGN | unpack, swap to larger-first, right-align smaller, detect specials
// ADD   | 28-bit magnitude add or subtract
// NORM  | carry shift-right or bounded leading-zero shift-left
// ROUND | RNE on G/R/S, overflow/special override, result registered
// DONE  | response valid until consumed
module fp_addsub_seq #(
  parameter int EXP_BITS = 8,
  parameter int SIG_BITS = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       opcode,
  input  logic                       sign1,
  input  logic                       sign2,
  input  logic [EXP_BITS-1:0]        exp1,
  input  logic [EXP_BITS-1:0]        exp2,
  input  logic [SIG_BITS-1:0]        sig1,
  input  logic [SIG_BITS-1:0]        sig2,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [EXP_BITS+SIG_BITS:0] fp_out,
  output logic [2:0]                 err_o
);
  localparam int MW  = SIG_BITS + 4;
  localparam int SW  = MW + 1;
  localparam int EW  = EXP_BITS + 1;
  localparam int FW  = EXP_BITS + SIG_BITS + 1;
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EXP_BITS-1:0] EMAX = '1;
  localparam logic [EXP_BITS-1:0] MW_E = EXP_BITS'(MW);
  localparam logic [FW-1:0] QNAN = {1'b0, EMAX, 1'b1, {(SIG_BITS-1){1'b0}}};
  localparam logic [2:0] ERR_NONE = 3'b000;
  localparam logic [2:0] ERR_OVF  = 3'b001;
  localparam logic [2:0] ERR_UNF  = 3'b010;
  localparam logic [2:0] ERR_INV  = 3'b011;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 opc_q, opc_d, s1_q, s1_d, s2_q, s2_d;
  logic [EXP_BITS-1:0]  e1_q, e1_d, e2_q, e2_d;
  logic [SIG_BITS-1:0]  f1_q, f1_d, f2_q, f2_d;
  logic                 sgn_q, sgn_d, sub_q, sub_d, spec_q, spec_d;
  logic [EW-1:0]        exp_q, exp_d;
  logic [MW-1:0]        mb_q, mb_d, ms_q, ms_d, mn_q, mn_d;
  logic [SW-1:0]        sum_q, sum_d;
  logic [FW-1:0]        spec_res_q, spec_res_d, fp_q, fp_d;
  logic [2:0]           spec_err_q, spec_err_d, err_q, err_d;

  logic                 eff_s2, swap, big_s, al_lost, nan1, nan2, inf1, inf2;
  logic                 spec_hit;
  logic [FW-1:0]        spec_res;
  logic [2:0]           spec_err;
  logic [EXP_BITS-1:0]  ea, eb, big_e, sml_e, diff;
  logic [SIG_BITS:0]    big_m, sml_m;
  logic [MW-1:0]        sml_fld, al_fld;
  logic [SW-1:0]        sum_c;
  logic [LZW-1:0]       lz;
  logic [EW-1:0]        lim, sh, nm_e, rd_e;
  logic [MW-1:0]        nm_m;
  logic [SIG_BITS:0]    rd_mant;
  logic [SIG_BITS+1:0]  rd_sum;
  logic [SIG_BITS-1:0]  rd_frac;
  logic                 rd_inc, rd_zero, rd_sign;
  logic [FW-1:0]        rd_res;
  logic [2:0]           rd_err;

  always_comb begin
    eff_s2  = s2_q ^ opc_q;
    ea      = (e1_q == '0) ? EXP_BITS'(1) : e1_q;
    eb      = (e2_q == '0) ? EXP_BITS'(1) : e2_q;
    swap    = {e2_q, f2_q} > {e1_q, f1_q};
    big_e   = swap ? eb : ea;
    sml_e   = swap ? ea : eb;
    big_m   = swap ? {e2_q != '0, f2_q} : {e1_q != '0, f1_q};
    sml_m   = swap ? {e1_q != '0, f1_q} : {e2_q != '0, f2_q};
    big_s   = swap ? eff_s2 : s1_q;
    diff    = big_e - sml_e;
    sml_fld = {sml_m, 3'b000};
    if (diff >= MW_E) begin
      al_fld  = '0;
      al_lost = |sml_m;
    end else begin
      al_fld  = sml_fld >> diff;
      al_lost = |(sml_fld & ~({MW{1'b1}} << diff));
    end
    nan1     = (e1_q == EMAX) && (f1_q != '0);
    nan2     = (e2_q == EMAX) && (f2_q != '0);
    inf1     = (e1_q == EMAX) && (f1_q == '0);
    inf2     = (e2_q == EMAX) && (f2_q == '0);
    spec_hit = 1'b1;
    spec_res = QNAN;
    spec_err = ERR_INV;
    if (nan1 || nan2 || (inf1 && inf2 && (s1_q != eff_s2))) begin
      spec_res = QNAN;
      spec_err = ERR_INV;
    end else if (inf1) begin
      spec_res = {s1_q, EMAX, {SIG_BITS{1'b0}}};
      spec_err = ERR_NONE;
    end else if (inf2) begin
      spec_res = {eff_s2, EMAX, {SIG_BITS{1'b0}}};
      spec_err = ERR_NONE;
    end else begin
      spec_hit = 1'b0;
    end
  end

  assign sum_c = sub_q ? ({1'b0, mb_q} - {1'b0, ms_q}) : ({1'b0, mb_q} + {1'b0, ms_q});

  // Left shift stops at exponent 1 so tiny results come out denormal.
  always_comb begin
    lz = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (sum_q[i]) lz = LZW'(MW - 1 - i);
    end
    lim = exp_q - EW'(1);
    sh  = (EW'(lz) > lim) ? lim : EW'(lz);
    if (sum_q[SW-1]) begin
      nm_m = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
      nm_e = exp_q + EW'(1);
    end else begin
      nm_m = sum_q[MW-1:0] << sh;
      nm_e = exp_q - sh;
    end
  end

  always_comb begin
    rd_mant = mn_q[MW-1:3];
    rd_inc  = mn_q[2] & (mn_q[1] | mn_q[0] | mn_q[3]);
    rd_sum  = {1'b0, rd_mant} + {{(SIG_BITS+1){1'b0}}, rd_inc};
    if (rd_sum[SIG_BITS+1]) begin
      rd_frac = rd_sum[SIG_BITS:1];
      rd_e    = exp_q + EW'(1);
    end else begin
      rd_frac = rd_sum[SIG_BITS-1:0];
      rd_e    = rd_sum[SIG_BITS] ? exp_q : '0;
    end
    rd_zero = (rd_e == '0) && (rd_frac == '0);
    rd_sign = sgn_q & ~(rd_zero & sub_q);
    if (spec_q) begin
      rd_res = spec_res_q;
      rd_err = spec_err_q;
    end else if (rd_e >= {1'b0, EMAX}) begin
      rd_res = {rd_sign, EMAX, {SIG_BITS{1'b0}}};
      rd_err = ERR_OVF;
    end else begin
      rd_res = {rd_sign, rd_e[EXP_BITS-1:0], rd_frac};
      rd_err = ((rd_e == '0) && ((rd_frac != '0) || (mn_q[2:0] != '0))) ? ERR_UNF : ERR_NONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    e1_d       = e1_q;
    e2_d       = e2_q;
    f1_d       = f1_q;
    f2_d       = f2_q;
    sgn_d      = sgn_q;
    sub_d      = sub_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_err_d = spec_err_q;
    exp_d      = exp_q;
    mb_d       = mb_q;
    ms_d       = ms_q;
    sum_d      = sum_q;
    mn_d       = mn_q;
    fp_d       = fp_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          opc_d   = opcode;
          s1_d    = sign1;
          s2_d    = sign2;
          e1_d    = exp1;
          e2_d    = exp2;
          f1_d    = sig1;
          f2_d    = sig2;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        sgn_d      = big_s;
        sub_d      = s1_q ^ eff_s2;
        exp_d      = {1'b0, big_e};
        mb_d       = {big_m, 3'b000};
        ms_d       = al_fld | {{(MW-1){1'b0}}, al_lost};
        spec_d     = spec_hit;
        spec_res_d = spec_res;
        spec_err_d = spec_err;
        state_d    = S_ADD;
      end
      S_ADD: begin
        sum_d   = sum_c;
        state_d = S_NORM;
      end
      S_NORM: begin
        mn_d    = nm_m;
        exp_d   = nm_e;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        fp_d    = rd_res;
        err_d   = rd_err;
        state_d = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      opc_q      <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      e1_q       <= '0;
      e2_q       <= '0;
      f1_q       <= '0;
      f2_q       <= '0;
      sgn_q      <= 1'b0;
      sub_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_err_q <= ERR_NONE;
      exp_q      <= '0;
      mb_q       <= '0;
      ms_q       <= '0;
      sum_q      <= '0;
      mn_q       <= '0;
      fp_q       <= '0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      e1_q       <= e1_d;
      e2_q       <= e2_d;
      f1_q       <= f1_d;
      f2_q       <= f2_d;
      sgn_q      <= sgn_d;
      sub_q      <= sub_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_err_q <= spec_err_d;
      exp_q      <= exp_d;
      mb_q       <= mb_d;
      ms_q       <= ms_d;
      sum_q      <= sum_d;
      mn_q       <= mn_d;
      fp_q       <= fp_d;
      err_q      <= err_d;
    end
  end

  assign fp_out = fp_q;
  assign err_o  = err_q;
endmodule
